overworld_move_sequencer: RTL and testbench

Sequences player movement on the overworld map. It arbitrates the four direction buttons once per video frame and queries an external collision/terrain lookup through a request/acknowledge handshake. It then animates a 16-pixel tile step at one pixel per frame, or a short bump animation when the destination is blocked. On arriving on grass it rolls a random encounter and holds the overworld frozen until the battle engine reports completion. It sits between the button debouncers and the map/sprite renderers, which consume `map_x`, `map_y`, `sprite_sel_x` and `sprite_sel_y`.

---
 rtl/overworld_move_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_overworld_move_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/overworld_move_sequencer.sv
// rtl/overworld_move_sequencer.sv - overworld tile-step sequencer: arbitration, collision query, walk/bump animation, encounters
module overworld_move_sequencer #(
  parameter int START_X     = 432,
  parameter int START_Y     = 312,
  parameter int STEP_PX     = 16,
  parameter int MAX_X       = 1008,
  parameter int MAX_Y       = 752,
  parameter int BUMP_FRAMES = 8,
  parameter int ENC_THRESH  = 26
) (
  input  logic        vclk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        enable,
  input  logic        up,
  input  logic        down,
  input  logic        left,
  input  logic        right,
  output logic        col_req,
  output logic [10:0] col_x,
  output logic [9:0]  col_y,
  input  logic        col_ack,
  input  logic        col_blocked,
  input  logic        col_grass,
  input  logic        battle_done,
  output logic [10:0] map_x,
  output logic [9:0]  map_y,
  output logic [1:0]  facing,
  output logic        walking,
  output logic [5:0]  sprite_sel_x,
  output logic [5:0]  sprite_sel_y,
  output logic        battle_trigger,
  output logic        in_battle
);

  typedef enum logic [2:0] {S_IDLE, S_QUERY, S_WALK, S_BUMP, S_ENC, S_BATTLE} state_t;

  localparam logic signed [12:0] STEP_S    = 13'(STEP_PX);
  localparam logic signed [12:0] LIM_X     = 13'(MAX_X);
  localparam logic signed [12:0] LIM_Y     = 13'(MAX_Y);
  localparam logic        [7:0]  STEP_C    = 8'(STEP_PX);
  localparam logic        [7:0]  HALF_STEP = 8'(STEP_PX / 2);
  localparam logic        [7:0]  BUMP_C    = 8'(BUMP_FRAMES);
  localparam logic        [7:0]  HALF_BUMP = 8'(BUMP_FRAMES / 2);
  localparam logic        [8:0]  ENC_T9    = 9'(ENC_THRESH);

  state_t      state_q, state_d;
  logic [10:0] map_x_q, map_x_d, dest_x_q, dest_x_d, col_x_q, col_x_d;
  logic [9:0]  map_y_q, map_y_d, dest_y_q, dest_y_d, col_y_q, col_y_d;
  logic [1:0]  facing_q, facing_d;
  logic [7:0]  cnt_q, cnt_d, lfsr_q, lfsr_d;
  logic [5:0]  sel_x_q, sel_x_d, sel_y_q, sel_y_d;
  logic        grass_q, grass_d, col_req_q, col_req_d, walking_q, walking_d;
  logic        trig_q, trig_d, in_battle_q, in_battle_d;

  logic [3:0]  held;
  logic        any_held, oob, enc_hit;
  logic [1:0]  sel_dir;
  logic signed [12:0] nx, ny;

  // held[] is indexed by facing code so the current direction can be looked up directly
  assign held     = {right, left, up, down};
  assign any_held = |held;
  assign lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign enc_hit  = {1'b0, lfsr_q} < ENC_T9;

  always_comb begin
    sel_dir = 2'd3;
    if (held[facing_q]) sel_dir = facing_q;
    else if (up)        sel_dir = 2'd1;
    else if (down)      sel_dir = 2'd0;
    else if (left)      sel_dir = 2'd2;
    nx = $signed({2'b00, map_x_q});
    ny = $signed({3'b000, map_y_q});
    case (sel_dir)
      2'd0:    ny = ny - STEP_S;
      2'd1:    ny = ny + STEP_S;
      2'd2:    nx = nx + STEP_S;
      default: nx = nx - STEP_S;
    endcase
    oob = (nx < 13'sd0) || (nx > LIM_X) || (ny < 13'sd0) || (ny > LIM_Y);
  end

  always_ff @(posedge vclk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      map_x_q     <= 11'(START_X);
      map_y_q     <= 10'(START_Y);
      dest_x_q    <= '0;
      dest_y_q    <= '0;
      col_x_q     <= '0;
      col_y_q     <= '0;
      facing_q    <= '0;
      cnt_q       <= '0;
      lfsr_q      <= 8'hA5;
      sel_x_q     <= '0;
      sel_y_q     <= '0;
      grass_q     <= 1'b0;
      col_req_q   <= 1'b0;
      walking_q   <= 1'b0;
      trig_q      <= 1'b0;
      in_battle_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      map_x_q     <= map_x_d;
      map_y_q     <= map_y_d;
      dest_x_q    <= dest_x_d;
      dest_y_q    <= dest_y_d;
      col_x_q     <= col_x_d;
      col_y_q     <= col_y_d;
      facing_q    <= facing_d;
      cnt_q       <= cnt_d;
      lfsr_q      <= lfsr_d;
      sel_x_q     <= sel_x_d;
      sel_y_q     <= sel_y_d;
      grass_q     <= grass_d;
      col_req_q   <= col_req_d;
      walking_q   <= walking_d;
      trig_q      <= trig_d;
      in_battle_q <= in_battle_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    map_x_d  = map_x_q;
    map_y_d  = map_y_q;
    dest_x_d = dest_x_q;
    dest_y_d = dest_y_q;
    facing_d = facing_q;
    cnt_d    = cnt_q;
    grass_d  = grass_q;
    sel_x_d  = sel_x_q;
    case (state_q)
      S_IDLE: if (frame_tick && enable && any_held) begin
        facing_d = sel_dir;
        dest_x_d = nx[10:0];
        dest_y_d = ny[9:0];
        cnt_d    = '0;
        if (oob) begin
          state_d = S_BUMP;
          sel_x_d = (HALF_BUMP != 8'd0) ? 6'd16 : 6'd0;
        end else begin
          state_d = S_QUERY;
        end
      end
      S_QUERY: if (col_ack && col_req_q) begin
        grass_d = col_grass;
        cnt_d   = '0;
        state_d = col_blocked ? S_BUMP : S_WALK;
        sel_x_d = (col_blocked && HALF_BUMP != 8'd0) ? 6'd16 : 6'd0;
      end
      S_WALK: if (frame_tick) begin
        if (map_x_q < dest_x_q)      map_x_d = map_x_q + 11'd1;
        else if (map_x_q > dest_x_q) map_x_d = map_x_q - 11'd1;
        if (map_y_q < dest_y_q)      map_y_d = map_y_q + 10'd1;
        else if (map_y_q > dest_y_q) map_y_d = map_y_q - 10'd1;
        cnt_d   = cnt_q + 8'd1;
        sel_x_d = (cnt_d >= HALF_STEP) ? 6'd16 : 6'd0;
        if (cnt_d == STEP_C) begin
          state_d = grass_q ? S_ENC : S_IDLE;
          sel_x_d = 6'd0;
        end
      end
      S_BUMP: if (frame_tick) begin
        cnt_d   = cnt_q + 8'd1;
        sel_x_d = (cnt_d < HALF_BUMP) ? 6'd16 : 6'd0;
        if (cnt_d >= BUMP_C) begin
          state_d = S_IDLE;
          sel_x_d = 6'd0;
        end
      end
      S_ENC:    state_d = enc_hit ? S_BATTLE : S_IDLE;
      S_BATTLE: if (battle_done) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    col_req_d   = (state_d == S_QUERY);
    col_x_d     = (state_d == S_QUERY) ? dest_x_d : col_x_q;
    col_y_d     = (state_d == S_QUERY) ? dest_y_d : col_y_q;
    walking_d   = (state_d == S_WALK);
    in_battle_d = (state_d == S_BATTLE);
    trig_d      = (state_q == S_ENC) && (state_d == S_BATTLE);
    sel_y_d     = {facing_d, 4'b0000};
  end

  assign col_req        = col_req_q;
  assign col_x          = col_x_q;
  assign col_y          = col_y_q;
  assign map_x          = map_x_q;
  assign map_y          = map_y_q;
  assign facing         = facing_q;
  assign walking        = walking_q;
  assign sprite_sel_x   = sel_x_q;
  assign sprite_sel_y   = sel_y_q;
  assign battle_trigger = trig_q;
  assign in_battle      = in_battle_q;

endmodule

// File: tb/tb_overworld_move_sequencer.sv
// tb/tb_overworld_move_sequencer.sv - randomized move transactions checked against a tile-level model
module tb_overworld_move_sequencer;
  localparam int SX = 32, SY = 744, ETH = 128;

  logic vclk = 1'b0;
  logic reset, frame_tick, enable, up, down, left, right;
  logic col_ack, col_blocked, col_grass, battle_done;
  logic col_req, walking, battle_trigger, in_battle;
  logic [10:0] col_x, map_x;
  logic [9:0] col_y, map_y;
  logic [1:0] facing;
  logic [5:0] sprite_sel_x, sprite_sel_y;

  int total = 0, bad = 0;
  int ex, ey, ef;
  logic [7:0] lfsr_m;

  overworld_move_sequencer #(.START_X(SX), .START_Y(SY), .ENC_THRESH(ETH)) dut (
    .vclk(vclk), .reset(reset), .frame_tick(frame_tick), .enable(enable),
    .up(up), .down(down), .left(left), .right(right),
    .col_req(col_req), .col_x(col_x), .col_y(col_y), .col_ack(col_ack),
    .col_blocked(col_blocked), .col_grass(col_grass), .battle_done(battle_done),
    .map_x(map_x), .map_y(map_y), .facing(facing), .walking(walking),
    .sprite_sel_x(sprite_sel_x), .sprite_sel_y(sprite_sel_y),
    .battle_trigger(battle_trigger), .in_battle(in_battle)
  );

  always #5 vclk = ~vclk;

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], ^(l & 8'hB8)};
  endfunction

  always @(posedge vclk) lfsr_m <= reset ? 8'hA5 : lfsr_step(lfsr_m);

  task automatic expect_eq(input string tag, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic check_pos(input string tag);
    expect_eq({tag, "_x"}, map_x, ex);
    expect_eq({tag, "_y"}, map_y, ey);
  endtask

  task automatic pulse_tick(input int gap);
    frame_tick = 1'b1;
    @(negedge vclk);
    frame_tick = 1'b0;
    repeat (gap) @(negedge vclk);
  endtask

  // b: {right, left, up, down}; abort_at >= 0 asserts reset after that many walk ticks
  task automatic do_move(input logic [3:0] b, input bit en, input bit blk, input bit grs,
                         input int dly, input bit drop_en, input int abort_at);
    int dir, dx, dy, nx, ny;
    bit oob, hit;
    dx = 0; dy = 0;
    {right, left, up, down} = b;
    enable = en;
    if (!en || b == 4'b0) begin
      col_ack = $urandom_range(0, 1);
      battle_done = $urandom_range(0, 1);
      pulse_tick(1);
      col_ack = 1'b0; battle_done = 1'b0;
      expect_eq("idle_req", col_req, 0);
      expect_eq("idle_walk", walking, 0);
      expect_eq("idle_battle", in_battle, 0);
      expect_eq("idle_face", facing, ef);
      check_pos("idle_pos");
      enable = 1'b1;
      return;
    end
    if (b[ef]) dir = ef;
    else if (b[1]) dir = 1;
    else if (b[0]) dir = 0;
    else if (b[2]) dir = 2;
    else dir = 3;
    case (dir)
      0: dy = -1;
      1: dy = 1;
      2: dx = 1;
      default: dx = -1;
    endcase
    nx = ex + 16 * dx;
    ny = ey + 16 * dy;
    oob = (nx < 0) || (nx > 1008) || (ny < 0) || (ny > 752);
    ef = dir;
    pulse_tick(0);
    expect_eq("sel_face", facing, dir);
    expect_eq("sel_row", sprite_sel_y, dir * 16);
    expect_eq("req_rise", col_req, !oob);
    if (!oob) begin
      expect_eq("col_x", col_x, nx);
      expect_eq("col_y", col_y, ny);
      repeat (dly) begin
        @(negedge vclk);
        expect_eq("req_hold", col_req, 1);
      end
      col_ack = 1'b1; col_blocked = blk; col_grass = grs;
      @(negedge vclk);
      col_ack = 1'b0; col_blocked = $urandom_range(0, 1); col_grass = $urandom_range(0, 1);
      expect_eq("req_fall", col_req, 0);
    end
    if (oob || blk) begin
      for (int k = 0; k < 8; k++) begin
        expect_eq("bump_selx", sprite_sel_x, (k < 4) ? 16 : 0);
        expect_eq("bump_walk", walking, 0);
        expect_eq("bump_req", col_req, 0);
        check_pos("bump_pos");
        pulse_tick($urandom_range(0, 2));
      end
      expect_eq("bump_end_selx", sprite_sel_x, 0);
      check_pos("bump_end_pos");
    end else begin
      for (int k = 0; k < 16; k++) begin
        expect_eq("walk_flag", walking, 1);
        expect_eq("walk_selx", sprite_sel_x, (k >= 8) ? 16 : 0);
        expect_eq("walk_x", map_x, ex + k * dx);
        expect_eq("walk_y", map_y, ey + k * dy);
        if (k == abort_at) begin
          reset = 1'b1;
          @(negedge vclk);
          reset = 1'b0;
          ex = SX; ey = SY; ef = 0;
          check_pos("abort_pos");
          expect_eq("abort_req", col_req, 0);
          expect_eq("abort_walk", walking, 0);
          expect_eq("abort_face", facing, 0);
          return;
        end
        if (drop_en && k == 5) enable = 1'b0;
        frame_tick = 1'b1;
        @(negedge vclk);
        frame_tick = 1'b0;
        if (k < 15) repeat ($urandom_range(0, 2)) @(negedge vclk);
      end
      ex = nx; ey = ny;
      check_pos("walk_end");
      expect_eq("walk_end_flag", walking, 0);
      expect_eq("walk_end_selx", sprite_sel_x, 0);
      expect_eq("trig_early", battle_trigger, 0);
      hit = grs && (int'(lfsr_m) < ETH);
      @(negedge vclk);
      expect_eq("trig", battle_trigger, hit);
      expect_eq("in_battle", in_battle, hit);
      @(negedge vclk);
      expect_eq("trig_once", battle_trigger, 0);
      if (hit) begin
        repeat (4) begin
          {right, left, up, down} = 4'($urandom_range(1, 15));
          pulse_tick(1);
          expect_eq("battle_hold", in_battle, 1);
          expect_eq("battle_req", col_req, 0);
          check_pos("battle_pos");
        end
        battle_done = 1'b1;
        @(negedge vclk);
        battle_done = 1'b0;
        expect_eq("battle_exit", in_battle, 0);
      end
    end
    enable = 1'b1;
  endtask

  initial begin
    reset = 1'b1; frame_tick = 1'b0; enable = 1'b1;
    {right, left, up, down} = 4'b0;
    col_ack = 1'b0; col_blocked = 1'b0; col_grass = 1'b0; battle_done = 1'b0;
    ex = SX; ey = SY; ef = 0;
    repeat (3) @(negedge vclk);
    check_pos("rst_pos");
    expect_eq("rst_face", facing, 0);
    expect_eq("rst_selx", sprite_sel_x, 0);
    expect_eq("rst_sely", sprite_sel_y, 0);
    expect_eq("rst_req", col_req, 0);
    expect_eq("rst_colx", col_x, 0);
    expect_eq("rst_coly", col_y, 0);
    expect_eq("rst_walk", walking, 0);
    expect_eq("rst_trig", battle_trigger, 0);
    expect_eq("rst_battle", in_battle, 0);
    reset = 1'b0;
    @(negedge vclk);

    do_move(4'b0001, 1, 0, 0, 3, 0, 7);
    do_move(4'b1110, 1, 0, 0, 2, 0, -1);
    do_move(4'b0011, 1, 0, 0, 2, 0, -1);
    do_move(4'b1000, 1, 1, 0, 1, 0, -1);
    do_move(4'b0001, 1, 0, 0, 3, 1, -1);
    do_move(4'b0000, 1, 0, 0, 0, 0, -1);
    do_move(4'b1000, 0, 0, 0, 0, 0, -1);
    for (int i = 0; i < 70; i++)
      do_move(4'($urandom_range(0, 15)), $urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 1) == 1, $urandom_range(0, 4), $urandom_range(0, 5) == 0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
